zbt_proc_reader: RTL and testbench

- Display-side reader for ZBT bank 1.
- Fetches the processed 36-bit words (two 18-bit pixels each) that the edge-processing path writes there.
- Issues read addresses from the VGA raster counters, absorbs the ZBT read latency, and emits one pixel per clock, aligned with delayed hsync/vsync/blank.
- Also owns the freeze handshake that lets the display hold a still frame while the writer is told to stop.

---
 rtl/zbt_pkg.sv | 33 +++
 rtl/sync_delay.sv | 26 ++
 rtl/zbt_proc_reader.sv | 145 ++++++++++++++
 tb/tb_zbt_proc_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_pkg.sv
// Shared ZBT bank-1 definitions: word/pixel geometry, freeze states, pipeline tag bundle.
// Used by both the display reader and the processed-frame writer.
package zbt_pkg;

  localparam int unsigned PIX_W   = 18;
  localparam int unsigned WORD_W  = 36;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned EVEN_HI = 35;
  localparam int unsigned ODD_HI  = 17;
  localparam int unsigned HCNT_W  = 11;
  localparam int unsigned VCNT_W  = 10;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    HOLD,
    RELEASE
  } frz_state_t;

  // Per-pixel side information that travels alongside the memory read.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic par;
    logic act;
  } pix_tag_t;

  localparam int unsigned TAG_W = $bits(pix_tag_t);

  localparam pix_tag_t TAG_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1, par: 1'b0, act: 1'b0};

endpackage

// File: rtl/sync_delay.sv
// N-deep, W-wide shift register with a programmable reset value.
module sync_delay #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(N); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[N-1];

endmodule

// File: rtl/zbt_proc_reader.sv
// Display-side reader for ZBT bank 1: raster-driven reads, latency absorption,
// one pixel per clock with aligned syncs, and the frame-boundary freeze handshake.
module zbt_proc_reader
  import zbt_pkg::*;
#(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_ACTIVE = 768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [35:0] mem_read_data,
  input  logic        freeze_req,
  output logic [18:0] read_addr,
  output logic        rd_en,
  output logic [17:0] pixel,
  output logic        d_hsync,
  output logic        d_vsync,
  output logic        d_blank,
  output logic        frozen,
  output logic        frame_start
);

  localparam int unsigned PIPE = READ_LAT + 2;

  logic                w_active;
  logic                w_rd_issue;
  logic [READ_LAT-1:0] r_rd_vld;
  logic                w_cap;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word_src;
  logic [PIX_W-1:0]    w_pix_nxt;
  pix_tag_t            w_tag_in;
  pix_tag_t            w_tag_dly;
  frz_state_t          r_state;
  frz_state_t          w_state_nxt;
  logic                w_frozen_nxt;
  logic                r_vsync_q;
  logic                w_vs_fall;

  assign w_active   = (hcount < HCNT_W'(H_ACTIVE)) && (vcount < VCNT_W'(V_ACTIVE));
  assign w_rd_issue = w_active && !hcount[0];

  // One read per even/odd pixel pair; the address holds while no read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr <= '0;
      rd_en     <= 1'b0;
      r_rd_vld  <= '0;
    end else begin
      rd_en    <= w_rd_issue;
      r_rd_vld <= (r_rd_vld << 1) | READ_LAT'(rd_en);
      if (w_rd_issue) read_addr <= {vcount, hcount[9:1]};
    end
  end

  assign w_cap = r_rd_vld[READ_LAT-1];

  always_comb begin
    w_tag_in       = TAG_IDLE;
    w_tag_in.hsync = hsync;
    w_tag_in.vsync = vsync;
    w_tag_in.blank = blank;
    w_tag_in.par   = hcount[0];
    w_tag_in.act   = w_active;
  end

  // Tag arrives in the same cycle as the memory data; the output register adds the last stage.
  sync_delay #(
    .N      (PIPE - 1),
    .W      (TAG_W),
    .RST_VAL(TAG_IDLE)
  ) u_tag_dly (
    .clk  (clk),
    .reset(reset),
    .i_d  (w_tag_in),
    .o_q  (w_tag_dly)
  );

  // Even pixel bypasses the word register so it lands in the same cycle it is captured.
  assign w_word_src = w_cap ? mem_read_data : r_word;

  always_comb begin
    w_pix_nxt = '0;
    if (w_tag_dly.act) begin
      w_pix_nxt = w_tag_dly.par ? w_word_src[ODD_HI -: PIX_W] : w_word_src[EVEN_HI -: PIX_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word  <= '0;
      pixel   <= '0;
      d_hsync <= 1'b1;
      d_vsync <= 1'b1;
      d_blank <= 1'b1;
    end else begin
      if (w_cap) r_word <= mem_read_data;
      pixel   <= w_pix_nxt;
      d_hsync <= w_tag_dly.hsync;
      d_vsync <= w_tag_dly.vsync;
      d_blank <= w_tag_dly.blank;
    end
  end

  assign w_vs_fall = r_vsync_q && !vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_vsync_q   <= 1'b1;
      frozen      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vsync_q   <= vsync;
      frozen      <= w_frozen_nxt;
      frame_start <= w_vs_fall;
    end
  end

  // Freeze state only commits or releases on a frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (freeze_req) w_state_nxt = PEND;
      PEND: begin
        if (!freeze_req)    w_state_nxt = RUN;
        else if (w_vs_fall) w_state_nxt = HOLD;
      end
      HOLD:    if (!freeze_req) w_state_nxt = RELEASE;
      RELEASE: begin
        if (freeze_req)     w_state_nxt = HOLD;
        else if (w_vs_fall) w_state_nxt = RUN;
      end
    endcase
    w_frozen_nxt = (w_state_nxt == HOLD) || (w_state_nxt == RELEASE);
  end

endmodule

// File: tb/tb_zbt_proc_reader.sv
// Self-checking bench for zbt_proc_reader: directed vector table, freeze/reset sequences,
// and randomized raster lines against a behavioural frame-level model.
module tb_zbt_proc_reader;

  localparam int PIPE = 4;
  localparam logic [35:0] FIXED_WORD = 36'h2_3456_789A;

  logic        clk;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic [35:0] mem_read_data;
  logic        freeze_req;
  logic [18:0] read_addr;
  logic        rd_en;
  logic [17:0] pixel;
  logic        d_hsync, d_vsync, d_blank;
  logic        frozen, frame_start;

  zbt_proc_reader dut (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank        (blank),
    .mem_read_data(mem_read_data),
    .freeze_req   (freeze_req),
    .read_addr    (read_addr),
    .rd_en        (rd_en),
    .pixel        (pixel),
    .d_hsync      (d_hsync),
    .d_vsync      (d_vsync),
    .d_blank      (d_blank),
    .frozen       (frozen),
    .frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ZBT memory model: contents are a function of address, data valid two clocks after the address.
  logic        fixed_mode;
  logic [31:0] seed;
  logic [35:0] m_q1;

  function automatic logic [35:0] word_of(input logic [18:0] a);
    if (fixed_mode) return FIXED_WORD;
    return (36'(a) * 36'd2654435761) ^ {seed, 4'h5};
  endfunction

  always @(posedge clk) begin
    m_q1          <= word_of(read_addr);
    mem_read_data <= m_q1;
  end

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, bl, fr;
    logic [18:0] e_addr;
    logic        e_rd;
    logic [17:0] e_pix;
    logic        e_frozen;
    logic        e_fs;
  } vec_t;

  typedef struct {
    logic [17:0] pix;
    logic        hs, vs, bl;
  } late_t;

  late_t lq[$];
  int    n_pass, n_chk;

  // Reference model state (frame-level, not RTL-structured)
  logic [18:0] m_addr;
  logic        m_prev_vs, m_prev_fr, m_frozen;
  logic [10:0] g_h;
  logic [9:0]  g_v;

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_init();
    m_addr    = '0;
    m_prev_vs = 1'b1;
    m_prev_fr = 1'b0;
    m_frozen  = 1'b0;
    lq.delete();
    for (int i = 0; i < PIPE - 1; i++) lq.push_back('{pix: 18'h0, hs: 1'b1, vs: 1'b1, bl: 1'b1});
  endtask

  task automatic finish_reset();
    repeat (2) @(negedge clk);
    model_init();
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t x);
    late_t o;
    hcount = x.h; vcount = x.v; hsync = x.hs; vsync = x.vs; blank = x.bl; freeze_req = x.fr;
    lq.push_back('{pix: x.e_pix, hs: x.hs, vs: x.vs, bl: x.bl});
    @(posedge clk);
    #1;
    chk("rd_en", 36'(rd_en), 36'(x.e_rd));
    chk("read_addr", 36'(read_addr), 36'(x.e_addr));
    chk("frozen", 36'(frozen), 36'(x.e_frozen));
    chk("frame_start", 36'(frame_start), 36'(x.e_fs));
    o = lq.pop_front();
    chk("pixel", 36'(pixel), 36'(o.pix));
    chk("d_hsync", 36'(d_hsync), 36'(o.hs));
    chk("d_vsync", 36'(d_vsync), 36'(o.vs));
    chk("d_blank", 36'(d_blank), 36'(o.bl));
    @(negedge clk);
  endtask

  // Expected outputs derived from raster position and frame-boundary freeze rules.
  task automatic step(input logic [10:0] h, input logic [9:0] v, input logic hs, input logic vs,
                      input logic bl, input logic fr);
    vec_t        x;
    logic        act;
    logic        fall;
    logic [35:0] w;
    act = (h < 11'd1024) && (v < 10'd768);
    if (act && !h[0]) m_addr = {v, h[9:1]};
    w = word_of({v, h[9:1]});
    fall = m_prev_vs && !vs;
    if (fall) begin
      if (!m_frozen && fr && m_prev_fr) m_frozen = 1'b1;
      else if (m_frozen && !fr && !m_prev_fr) m_frozen = 1'b0;
    end
    x.h = h; x.v = v; x.hs = hs; x.vs = vs; x.bl = bl; x.fr = fr;
    x.e_rd     = act && !h[0];
    x.e_addr   = m_addr;
    x.e_pix    = !act ? 18'h0 : (h[0] ? w[17:0] : w[35:18]);
    x.e_frozen = m_frozen;
    x.e_fs     = fall;
    m_prev_vs = vs;
    m_prev_fr = fr;
    apply(x);
  endtask

  task automatic tick(input logic vs, input logic fr);
    logic hs, bl;
    hs = !(g_h >= 11'd1048 && g_h < 11'd1184);
    bl = !(g_h < 11'd1024 && g_v < 10'd768);
    step(g_h, g_v, hs, vs, bl, fr);
    if (g_h == 11'd1343) begin
      g_h = '0;
      g_v = (g_v == 10'd805) ? 10'd0 : g_v + 10'd1;
    end else begin
      g_h = g_h + 11'd1;
    end
  endtask

  function automatic vec_t mkv(input logic [10:0] h, input logic [9:0] v, input logic hs,
                               input logic bl, input logic [18:0] ea, input logic erd,
                               input logic [17:0] ep);
    vec_t x;
    x.h = h; x.v = v; x.hs = hs; x.vs = 1'b1; x.bl = bl; x.fr = 1'b0;
    x.e_addr = ea; x.e_rd = erd; x.e_pix = ep; x.e_frozen = 1'b0; x.e_fs = 1'b0;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    n_pass = 0; n_chk = 0;
    fixed_mode = 1'b1; seed = 32'h0;
    reset = 1'b1;
    hcount = 11'd1100; vcount = 10'd0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1; freeze_req = 1'b0;
    #1;
    chk("rst_read_addr", 36'(read_addr), 36'h0);
    chk("rst_rd_en", 36'(rd_en), 36'h0);
    chk("rst_pixel", 36'(pixel), 36'h0);
    chk("rst_frozen", 36'(frozen), 36'h0);
    chk("rst_frame_start", 36'(frame_start), 36'h0);
    chk("rst_syncs", 36'({d_hsync, d_vsync, d_blank}), 36'h7);
    finish_reset();

    tbl.push_back(mkv(11'd0,    10'd5,   1'b1, 1'b0, 19'h00A00, 1'b1, 18'h08D15));
    tbl.push_back(mkv(11'd1,    10'd5,   1'b1, 1'b0, 19'h00A00, 1'b0, 18'h2789A));
    tbl.push_back(mkv(11'd2,    10'd5,   1'b1, 1'b0, 19'h00A01, 1'b1, 18'h08D15));
    tbl.push_back(mkv(11'd3,    10'd5,   1'b1, 1'b0, 19'h00A01, 1'b0, 18'h2789A));
    tbl.push_back(mkv(11'd1024, 10'd10,  1'b1, 1'b1, 19'h00A01, 1'b0, 18'h0));
    tbl.push_back(mkv(11'd1100, 10'd10,  1'b0, 1'b1, 19'h00A01, 1'b0, 18'h0));
    tbl.push_back(mkv(11'd1343, 10'd10,  1'b1, 1'b1, 19'h00A01, 1'b0, 18'h0));
    tbl.push_back(mkv(11'd1022, 10'd767, 1'b1, 1'b0, 19'h5FFFF, 1'b1, 18'h08D15));
    tbl.push_back(mkv(11'd1023, 10'd767, 1'b1, 1'b0, 19'h5FFFF, 1'b0, 18'h2789A));
    tbl.push_back(mkv(11'd1024, 10'd767, 1'b0, 1'b1, 19'h5FFFF, 1'b0, 18'h0));
    tbl.push_back(mkv(11'd0,    10'd0,   1'b1, 1'b0, 19'h00000, 1'b1, 18'h08D15));
    tbl.push_back(mkv(11'd1,    10'd0,   1'b1, 1'b0, 19'h00000, 1'b0, 18'h2789A));
    tbl.push_back(mkv(11'd0,    10'd768, 1'b1, 1'b1, 19'h00000, 1'b0, 18'h0));
    tbl.push_back(mkv(11'd5,    10'd770, 1'b0, 1'b1, 19'h00000, 1'b0, 18'h0));
    for (int i = 0; i < PIPE; i++) tbl.push_back(mkv(11'd1200, 10'd771, 1'b1, 1'b1, 19'h0, 1'b0, 18'h0));
    foreach (tbl[i]) apply(tbl[i]);

    // Freeze handshake sequences
    fixed_mode = 1'b0; seed = $urandom;
    reset = 1'b1; #1; finish_reset();
    g_h = '0; g_v = '0;
    repeat (300) tick(1'b1, 1'b0);
    repeat (200) tick(1'b1, 1'b1);
    chk("pend_not_frozen", 36'(frozen), 36'h0);
    tick(1'b0, 1'b1);
    chk("freeze_at_edge", 36'(frozen), 36'h1);
    chk("fs_at_freeze_edge", 36'(frame_start), 36'h1);
    repeat (20) tick(1'b0, 1'b1);
    repeat (100) tick(1'b1, 1'b1);
    repeat (200) tick(1'b1, 1'b0);
    chk("hold_after_drop", 36'(frozen), 36'h1);
    tick(1'b0, 1'b0);
    chk("release_at_edge", 36'(frozen), 36'h0);
    chk("fs_at_release_edge", 36'(frame_start), 36'h1);
    repeat (50) tick(1'b0, 1'b0);
    repeat (100) tick(1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b1);
    repeat (100) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pulse_no_freeze", 36'(frozen), 36'h0);
    repeat (50) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    chk("simul_edge_no_freeze", 36'(frozen), 36'h0);
    chk("simul_edge_fs", 36'(frame_start), 36'h1);
    repeat (30) tick(1'b0, 1'b1);
    repeat (30) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("simul_next_edge_freeze", 36'(frozen), 36'h1);
    repeat (10) tick(1'b1, 1'b1);
    for (int k = 0; k < 2000 && !(g_h > 11'd10 && g_h < 11'd1000 && g_v < 10'd768); k++) tick(1'b1, 1'b1);

    // Asynchronous reset mid-line while frozen
    reset = 1'b1;
    #1;
    chk("midrst_pixel", 36'(pixel), 36'h0);
    chk("midrst_rd_en", 36'(rd_en), 36'h0);
    chk("midrst_frozen", 36'(frozen), 36'h0);
    finish_reset();
    g_h = '0;
    repeat (400) tick(1'b1, 1'b0);

    // Randomized raster lines with random freeze activity and frame boundaries
    for (int l = 0; l < 20; l++) begin
      logic vs_line;
      logic fr;
      if (l == 0) g_v = 10'd767;
      else if (l % 5 == 4) g_v = 10'(768 + $urandom_range(0, 37));
      else g_v = 10'($urandom_range(0, 767));
      g_h = '0;
      vs_line = !(l % 4 == 2);
      fr = 1'($urandom_range(0, 1));
      for (int h = 0; h < 1344; h++) begin
        if ($urandom_range(0, 599) == 0) fr = !fr;
        tick((h < 200) ? vs_line : 1'b1, fr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
